race_flow_ctrl: RTL and testbench

- Frame-rate game sequencer that drives the pixel compositor and the sprite engines.
- Collects per-pixel hit flags during each frame and latches them at startOfFrame. Runs the race state machine and outputs:
  - scroll speed
  - message-board select
  - overlay enables
  - score
  - lives
  - one-frame sound requests
- Sits between the compositor's hit outputs and the background/sprite/message generators. Everything except hit collection updates once per frame.

---
 rtl/game_pkg.sv | 34 +++
 rtl/race_flow_ctrl_hit_latch.sv | 30 +++
 rtl/race_flow_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_race_flow_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the race game sequencer.
// State codes, message-board selects and score saturation helper.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RACE      = 3'd2,
    ST_CRASH     = 3'd3,
    ST_FINISH    = 3'd4,
    ST_GAME_OVER = 3'd5
  } flow_state_t;

  localparam logic [1:0] MSG_NONE  = 2'd0;
  localparam logic [1:0] MSG_READY = 2'd1;
  localparam logic [1:0] MSG_CRASH = 2'd2;
  localparam logic [1:0] MSG_END   = 2'd3;

  localparam logic [13:0] SCORE_MAX = 14'd9999;

  localparam int HIT_CRASH  = 0;
  localparam int HIT_BONUS  = 1;
  localparam int HIT_FINISH = 2;

  function automatic logic [13:0] sat_add(
    input logic [13:0] a,
    input logic [13:0] b
  );
    logic [14:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, SCORE_MAX}) ? SCORE_MAX : s[13:0];
  endfunction

endpackage

// File: rtl/race_flow_ctrl_hit_latch.sv
// Sticky per-pixel hit capture with per-frame sampling.
// A hit on the frame-start clock belongs to the new frame.
module hit_latch
  import game_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         sof,
  input  logic [N-1:0] hit,
  output logic [N-1:0] sampled
);

  logic [N-1:0] flags;

  // accumulate hits, hand them over and restart at frame start
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flags   <= '0;
      sampled <= '0;
    end else if (sof) begin
      sampled <= flags;
      flags   <= hit;
    end else begin
      flags   <= flags | hit;
    end
  end

endmodule

// File: rtl/race_flow_ctrl.sv
// Frame-rate race sequencer: state, speed, score, lives, sounds.
// Evaluates the previous frame's hits one clock after startOfFrame.
module race_flow_ctrl
  import game_pkg::*;
#(
  parameter int COUNTDOWN_FRAMES = 90,
  parameter int CRASH_FRAMES     = 60,
  parameter int FINISH_FRAMES    = 150,
  parameter int MAX_SPEED        = 8,
  parameter int ACCEL_DIV        = 4,
  parameter int START_LIVES      = 3,
  parameter int BONUS_POINTS     = 50
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_key,
  input  logic        accel_key,
  input  logic        crash_hit,
  input  logic        bonus_hit,
  input  logic        finish_hit,
  output logic [2:0]  state_o,
  output logic [3:0]  speed,
  output logic [1:0]  msg_sel,
  output logic        bar_en,
  output logic [13:0] score,
  output logic [1:0]  lives,
  output logic        snd_crash,
  output logic        snd_bonus,
  output logic        snd_finish
);

  localparam logic [7:0]  CD_LAST  = 8'(COUNTDOWN_FRAMES - 1);
  localparam logic [7:0]  CR_LAST  = 8'(CRASH_FRAMES - 1);
  localparam logic [7:0]  FN_LAST  = 8'(FINISH_FRAMES - 1);
  localparam logic [7:0]  AC_LAST  = 8'(ACCEL_DIV - 1);
  localparam logic [3:0]  SPD_MAX  = 4'(MAX_SPEED);
  localparam logic [1:0]  LIVES_0  = 2'(START_LIVES);
  localparam logic [13:0] BONUS    = 14'(BONUS_POINTS);

  flow_state_t state, state_n;
  logic [2:0]  hits;
  logic        tick;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  speed_n;
  logic [13:0] score_n;
  logic [1:0]  lives_n;
  logic [2:0]  snd, snd_n;

  hit_latch #(.N(3)) u_hit (
    .clk     (clk),
    .resetN  (resetN),
    .sof     (startOfFrame),
    .hit     ({finish_hit, bonus_hit, crash_hit}),
    .sampled (hits)
  );

  // frame tick one clock after the frame pulse
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) tick <= 1'b0;
    else         tick <= startOfFrame;
  end

  // game registers, only change on a tick
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= ST_IDLE;
      cnt   <= '0;
      speed <= '0;
      score <= '0;
      lives <= '0;
      snd   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      speed <= speed_n;
      score <= score_n;
      lives <= lives_n;
      snd   <= snd_n;
    end
  end

  // next-state and datapath update per frame
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    speed_n = speed;
    score_n = score;
    lives_n = lives;
    snd_n   = snd;
    if (tick) begin
      snd_n = '0;
      case (state)
        ST_IDLE: begin
          speed_n = '0;
          if (start_key) begin
            lives_n = LIVES_0;
            score_n = '0;
            cnt_n   = '0;
            state_n = ST_COUNTDOWN;
          end
        end
        ST_COUNTDOWN: begin
          if (cnt == CD_LAST) begin
            cnt_n   = '0;
            speed_n = 4'd1;
            state_n = ST_RACE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        ST_RACE: begin
          if (hits[HIT_FINISH]) begin
            snd_n[HIT_FINISH] = 1'b1;
            speed_n = '0;
            cnt_n   = '0;
            state_n = ST_FINISH;
          end else if (hits[HIT_CRASH]) begin
            snd_n[HIT_CRASH] = 1'b1;
            lives_n = lives - 2'd1;
            speed_n = '0;
            cnt_n   = '0;
            state_n = (lives == 2'd1) ? ST_GAME_OVER : ST_CRASH;
          end else begin
            if (hits[HIT_BONUS]) begin
              snd_n[HIT_BONUS] = 1'b1;
              score_n = sat_add(score, BONUS);
            end
            if (cnt == AC_LAST) begin
              cnt_n = '0;
              if (accel_key)
                speed_n = (speed >= SPD_MAX) ? SPD_MAX : speed + 4'd1;
              else
                speed_n = (speed <= 4'd1) ? 4'd1 : speed - 4'd1;
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end
        end
        ST_CRASH: begin
          if (cnt == CR_LAST) begin
            cnt_n   = '0;
            speed_n = 4'd1;
            state_n = ST_RACE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        ST_FINISH: begin
          if (cnt == FN_LAST) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        ST_GAME_OVER: begin
          if (start_key) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
          end
        end
        default: begin
          cnt_n   = '0;
          speed_n = '0;
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // message board and overlay follow the state
  always_comb begin
    msg_sel = MSG_READY;
    bar_en  = 1'b0;
    unique case (state)
      ST_COUNTDOWN: bar_en = 1'b1;
      ST_RACE: begin
        msg_sel = MSG_NONE;
        bar_en  = 1'b1;
      end
      ST_CRASH:     msg_sel = MSG_CRASH;
      ST_FINISH:    msg_sel = MSG_END;
      ST_GAME_OVER: msg_sel = MSG_END;
      default:      msg_sel = MSG_READY;
    endcase
  end

  assign state_o    = state;
  assign snd_crash  = snd[HIT_CRASH];
  assign snd_bonus  = snd[HIT_BONUS];
  assign snd_finish = snd[HIT_FINISH];

endmodule

// File: tb/tb_race_flow_ctrl.sv
// Bench for race_flow_ctrl: frame-level reference model,
// randomized hits/keys, directed game scenarios.
module tb_race_flow_ctrl;

  localparam int FL = 8;
  localparam int S_IDLE = 0, S_CD = 1, S_RACE = 2;
  localparam int S_CRASH = 3, S_FIN = 4, S_GO = 5;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame, start_key, accel_key;
  logic        crash_hit, bonus_hit, finish_hit;
  logic [2:0]  state_o;
  logic [3:0]  speed;
  logic [1:0]  msg_sel;
  logic        bar_en;
  logic [13:0] score;
  logic [1:0]  lives;
  logic        snd_crash, snd_bonus, snd_finish;

  int total = 0;
  int bad   = 0;

  int m_st, m_speed, m_score, m_lives, m_n;
  bit m_sc, m_sb, m_sf;
  bit pc, pb, pf;

  race_flow_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .start_key    (start_key),
    .accel_key    (accel_key),
    .crash_hit    (crash_hit),
    .bonus_hit    (bonus_hit),
    .finish_hit   (finish_hit),
    .state_o      (state_o),
    .speed        (speed),
    .msg_sel      (msg_sel),
    .bar_en       (bar_en),
    .score        (score),
    .lives        (lives),
    .snd_crash    (snd_crash),
    .snd_bonus    (snd_bonus),
    .snd_finish   (snd_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_msg(input int st);
    case (st)
      S_RACE:       return 0;
      S_CRASH:      return 2;
      S_FIN, S_GO:  return 3;
      default:      return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_speed = 0; m_score = 0; m_lives = 0; m_n = 0;
    m_sc = 0; m_sb = 0; m_sf = 0;
    pc = 0; pb = 0; pf = 0;
  endtask

  task automatic model_tick(input bit sk, input bit ak);
    m_sc = 0; m_sb = 0; m_sf = 0;
    case (m_st)
      S_IDLE: if (sk) begin
        m_lives = 3; m_score = 0; m_n = 0; m_st = S_CD;
      end
      S_CD: begin
        m_n++;
        if (m_n == 90) begin m_st = S_RACE; m_speed = 1; m_n = 0; end
      end
      S_RACE: begin
        if (pf) begin
          m_sf = 1; m_speed = 0; m_n = 0; m_st = S_FIN;
        end else if (pc) begin
          m_sc = 1; m_speed = 0; m_n = 0; m_lives--;
          m_st = (m_lives == 0) ? S_GO : S_CRASH;
        end else begin
          if (pb) begin
            m_sb = 1;
            m_score = (m_score + 50 > 9999) ? 9999 : m_score + 50;
          end
          m_n++;
          if (m_n % 4 == 0) begin
            if (ak) m_speed = (m_speed < 8) ? m_speed + 1 : 8;
            else    m_speed = (m_speed > 1) ? m_speed - 1 : 1;
          end
        end
      end
      S_CRASH: begin
        m_n++;
        if (m_n == 60) begin m_st = S_RACE; m_speed = 1; m_n = 0; end
      end
      S_FIN: begin
        m_n++;
        if (m_n == 150) begin m_st = S_IDLE; m_n = 0; end
      end
      S_GO: if (sk) begin m_st = S_IDLE; m_n = 0; end
      default: m_st = S_IDLE;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 16'(state_o), 16'(m_st));
    chk({tag, ".speed"}, 16'(speed), 16'(m_speed));
    chk({tag, ".msg"}, 16'(msg_sel), 16'(exp_msg(m_st)));
    chk({tag, ".bar"}, 16'(bar_en), 16'(m_st == S_CD || m_st == S_RACE));
    chk({tag, ".score"}, 16'(score), 16'(m_score));
    chk({tag, ".lives"}, 16'(lives), 16'(m_lives));
    chk({tag, ".snd"}, 16'({snd_finish, snd_bonus, snd_crash}),
        16'({m_sf, m_sb, m_sc}));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".state"}, 16'(state_o), 16'd0);
    chk({tag, ".speed"}, 16'(speed), 16'd0);
    chk({tag, ".msg"}, 16'(msg_sel), 16'd1);
    chk({tag, ".bar"}, 16'(bar_en), 16'd0);
    chk({tag, ".score"}, 16'(score), 16'd0);
    chk({tag, ".lives"}, 16'(lives), 16'd0);
    chk({tag, ".snd"}, 16'({snd_finish, snd_bonus, snd_crash}), 16'd0);
  endtask

  // one frame: keys held all frame, each requested hit pulsed once
  // at clock 'pos' of the frame (0 = the startOfFrame clock)
  task automatic frame(input bit sk, input bit ak, input bit c,
                       input bit b, input bit f, input int pos);
    @(negedge clk);
    start_key = sk; accel_key = ak; startOfFrame = 1'b1;
    crash_hit = c && pos == 0;
    bonus_hit = b && pos == 0;
    finish_hit = f && pos == 0;
    @(negedge clk);
    startOfFrame = 1'b0;
    model_tick(sk, ak);
    pc = c; pb = b; pf = f;
    for (int k = 1; k < FL; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) check_all("tick");
      if (k == FL - 1) check_all("hold");
      crash_hit = c && pos == k;
      bonus_hit = b && pos == k;
      finish_hit = f && pos == k;
    end
  endtask

  function automatic int rpos();
    return int'($urandom_range(0, FL - 1));
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic start_and_countdown();
    frame(1, rb(), 0, 0, 0, 0);
    chk("start.state", 16'(state_o), 16'd1);
    for (int j = 1; j <= 90; j++)
      frame(rb(), rb(), (j < 89) && rb(), (j < 89) && rb(),
            (j < 89) && rb(), rpos());
    chk("cd_done.state", 16'(state_o), 16'd2);
    chk("cd_done.speed", 16'(speed), 16'd1);
    chk("cd_done.msg", 16'(msg_sel), 16'd0);
    chk("cd_done.lives", 16'(lives), 16'd3);
  endtask

  task automatic crash_period();
    for (int j = 1; j <= 60; j++)
      frame(rb(), rb(), (j < 59) && rb(), (j < 59) && rb(),
            (j < 59) && rb(), rpos());
    chk("recover.state", 16'(state_o), 16'd2);
    chk("recover.speed", 16'(speed), 16'd1);
  endtask

  initial begin
    model_reset();
    resetN = 1'b0;
    startOfFrame = 0; start_key = 0; accel_key = 0;
    crash_hit = 0; bonus_hit = 0; finish_hit = 0;
    #12;
    check_reset("reset");
    @(negedge clk);
    resetN = 1'b1;

    for (int j = 0; j < 4; j++) frame(0, rb(), rb(), rb(), rb(), rpos());
    start_and_countdown();

    for (int j = 0; j < 40; j++) frame(0, 1, 0, 0, 0, 0);
    chk("accel.speed", 16'(speed), 16'd8);
    for (int j = 0; j < 40; j++) frame(0, 0, 0, 0, 0, 0);
    chk("decay.speed", 16'(speed), 16'd1);

    frame(0, rb(), 1, 0, 0, rpos());
    frame(0, rb(), 0, 0, 0, 0);
    chk("crash.state", 16'(state_o), 16'd3);
    chk("crash.lives", 16'(lives), 16'd2);
    chk("crash.snd", 16'(snd_crash), 16'd1);
    crash_period();

    frame(0, 0, 0, 1, 0, 0);
    frame(0, 0, 0, 0, 0, 0);
    chk("sof_hit.score", 16'(score), 16'd50);

    frame(0, rb(), 1, 1, 1, rpos());
    frame(0, rb(), 0, 0, 0, 0);
    chk("prio.state", 16'(state_o), 16'd4);
    chk("prio.snd", 16'({snd_finish, snd_bonus, snd_crash}), 16'd4);
    chk("prio.score", 16'(score), 16'd50);
    for (int j = 0; j < 150; j++) frame(0, rb(), rb(), rb(), rb(), rpos());
    chk("fin_done.state", 16'(state_o), 16'd0);
    chk("fin_done.score", 16'(score), 16'd50);

    start_and_countdown();
    for (int j = 0; j < 199; j++) frame(0, rb(), 0, 1, 0, rpos());
    frame(0, rb(), 0, 0, 0, 0);
    chk("bonus.score", 16'(score), 16'd9950);
    frame(0, rb(), 0, 1, 0, rpos());
    frame(0, rb(), 0, 1, 0, rpos());
    frame(0, rb(), 0, 0, 0, 0);
    chk("sat.score", 16'(score), 16'd9999);

    frame(0, rb(), 1, rb(), 0, rpos());
    frame(0, rb(), 0, 0, 0, 0);
    crash_period();
    frame(0, rb(), 1, 0, 0, rpos());
    frame(0, rb(), 0, 0, 0, 0);
    chk("crash2.lives", 16'(lives), 16'd1);
    crash_period();
    frame(0, rb(), 1, rb(), 0, rpos());
    frame(0, rb(), 0, 0, 0, 0);
    chk("gameover.state", 16'(state_o), 16'd5);
    chk("gameover.lives", 16'(lives), 16'd0);
    chk("gameover.msg", 16'(msg_sel), 16'd3);
    frame(0, rb(), rb(), rb(), rb(), rpos());
    frame(1, rb(), 0, 0, 0, 0);
    chk("go_exit.state", 16'(state_o), 16'd0);

    frame(1, rb(), 0, 0, 0, 0);
    for (int j = 0; j < 10; j++) frame(rb(), rb(), rb(), rb(), rb(), rpos());
    #2;
    resetN = 1'b0;
    crash_hit = 0; bonus_hit = 0; finish_hit = 0;
    #1;
    check_reset("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    for (int j = 0; j < 3; j++) frame(0, rb(), rb(), rb(), rb(), rpos());
    frame(1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 5; j++) frame(rb(), rb(), 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
